// File: rtl/pc_pkg.sv
// Shared definitions for the PC/trap-vector block: cause codes, vector offsets
// and the cause type.
package pc_pkg;

  typedef logic [3:0] cause_t;

  localparam cause_t CAUSE_NONE     = 4'd0;
  localparam cause_t CAUSE_EXC      = 4'd1;
  localparam cause_t CAUSE_IRQ_BASE = 4'd2;

  localparam int EXC_OFFSET = 4;
  localparam int IRQ_OFFSET = 8;
  localparam int IRQ_STRIDE = 4;

  // Up to 8 interrupt lines, so a 3-bit index always suffices.
  localparam int IDX_W = 3;

  function automatic cause_t irq_cause(input logic [IDX_W-1:0] idx);
    return CAUSE_IRQ_BASE + cause_t'(idx);
  endfunction

endpackage

// File: rtl/irq_prio.sv
// Masked lowest-index priority encoder: reports whether any enabled request
// is present and the index of the lowest one.
module irq_prio
  import pc_pkg::*;
#(
  parameter int NIRQ = 4
) (
  input  logic [NIRQ-1:0]  req,
  input  logic [NIRQ-1:0]  mask,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest enabled index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i] && mask[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pc_vec.sv
// Instruction-address register with exception, interrupt and trap-return
// vectoring; the top bit of ia marks supervisor mode.
module pc_vec
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NIRQ      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h8000_0000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcin,
  input  logic             stall,
  input  logic             exception,
  input  logic [NIRQ-1:0]  irq,
  input  logic [NIRQ-1:0]  irq_mask,
  input  logic             eret,
  output logic [WIDTH-1:0] ia,
  output logic [WIDTH-1:0] epc,
  output logic [3:0]       cause,
  output logic [NIRQ-1:0]  irq_ack,
  output logic [NIRQ-1:0]  pending
);

  logic             supervisor;
  logic [NIRQ-1:0]  irq_req;
  logic             irq_valid;
  logic [IDX_W-1:0] irq_idx;
  logic [NIRQ-1:0]  irq_onehot;
  logic [WIDTH-1:0] exc_vec;
  logic [WIDTH-1:0] irq_vec;

  logic [WIDTH-1:0] ia_n;
  logic [WIDTH-1:0] epc_n;
  cause_t           cause_n;
  logic [NIRQ-1:0]  ack_n;
  logic [NIRQ-1:0]  clr;
  logic [NIRQ-1:0]  pending_n;

  assign supervisor = ia[WIDTH-1];
  assign irq_req    = (pending | irq) & {NIRQ{~supervisor}};
  assign irq_onehot = NIRQ'(1) << irq_idx;
  assign exc_vec    = RESET_VEC + WIDTH'(EXC_OFFSET);
  assign irq_vec    = RESET_VEC + WIDTH'(IRQ_OFFSET) + WIDTH'(IRQ_STRIDE * int'(irq_idx));

  irq_prio #(
    .NIRQ (NIRQ)
  ) u_irq_prio (
    .req   (irq_req),
    .mask  (irq_mask),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  always_comb begin
    ia_n    = pcin;
    epc_n   = epc;
    cause_n = cause;
    ack_n   = '0;
    clr     = '0;
    if (stall) begin
      ia_n = ia;
    end else if (exception) begin
      ia_n    = exc_vec;
      epc_n   = pcin;
      cause_n = CAUSE_EXC;
    end else if (irq_valid) begin
      ia_n    = irq_vec;
      epc_n   = pcin;
      cause_n = irq_cause(irq_idx);
      ack_n   = irq_onehot;
      clr     = irq_onehot;
    end else if (eret) begin
      ia_n = epc;
    end
  end

  // A taken line clears unless it was already pending and pulsed again this cycle.
  assign pending_n = ((pending | irq) & ~clr) | (pending & irq);

  always_ff @(posedge clk) begin
    if (reset) begin
      ia      <= RESET_VEC;
      epc     <= '0;
      cause   <= CAUSE_NONE;
      irq_ack <= '0;
      pending <= '0;
    end else begin
      ia      <= ia_n;
      epc     <= epc_n;
      cause   <= cause_n;
      irq_ack <= ack_n;
      pending <= pending_n;
    end
  end

endmodule

// File: tb/tb_pc_vec.sv
// Directed self-checking bench for pc_vec: one task per scenario with
// hand-computed expectations.
module tb_pc_vec;

  logic        clk;
  logic        reset;
  logic [31:0] pcin;
  logic        stall;
  logic        exception;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        eret;
  logic [31:0] ia;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic [3:0]  irq_ack;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  pc_vec dut (
    .clk       (clk),
    .reset     (reset),
    .pcin      (pcin),
    .stall     (stall),
    .exception (exception),
    .irq       (irq),
    .irq_mask  (irq_mask),
    .eret      (eret),
    .ia        (ia),
    .epc       (epc),
    .cause     (cause),
    .irq_ack   (irq_ack),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset     = 1'b0;
    stall     = 1'b0;
    exception = 1'b0;
    irq       = 4'b0000;
    irq_mask  = 4'b1111;
    eret      = 1'b0;
  endtask

  // Reset, then one plain cycle so ia sits at a user-mode address.
  task automatic to_user(input logic [31:0] addr);
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    pcin  = addr;
    cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; stall = 1'b1; exception = 1'b1; irq = 4'b1111; eret = 1'b1;
    pcin = 32'h1234_5678;
    cycle();
    n_checks++; if (ia !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL reset_ia: got %h expected %h", ia, 32'h8000_0000); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_pending: got %b expected %b", pending, 4'b0000); end
    n_checks++; if (cause !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_cause: got %0d expected %0d", cause, 0); end
    n_checks++; if (epc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_epc: got %h expected %h", epc, 32'h0); end
    n_checks++; if (irq_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ack: got %b expected %b", irq_ack, 4'b0000); end
  endtask

  task automatic test_supervisor_latch();
    idle_inputs();
    pcin = 32'h8000_0200;
    irq  = 4'b0001;
    cycle();
    n_checks++; if (ia !== 32'h8000_0200) begin n_fail++; $display("[TB] FAIL sup_ia: got %h expected %h", ia, 32'h8000_0200); end
    n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("[TB] FAIL sup_pending: got %b expected %b", pending, 4'b0001); end
    n_checks++; if (irq_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL sup_ack: got %b expected %b", irq_ack, 4'b0000); end
  endtask

  task automatic test_irq_take();
    to_user(32'h0000_1000);
    n_checks++; if (ia !== 32'h0000_1000) begin n_fail++; $display("[TB] FAIL take_user_ia: got %h expected %h", ia, 32'h0000_1000); end
    pcin = 32'h0000_1004; irq = 4'b0110; irq_mask = 4'b1111;
    cycle();
    n_checks++; if (ia !== 32'h8000_000C) begin n_fail++; $display("[TB] FAIL take_ia: got %h expected %h", ia, 32'h8000_000C); end
    n_checks++; if (epc !== 32'h0000_1004) begin n_fail++; $display("[TB] FAIL take_epc: got %h expected %h", epc, 32'h0000_1004); end
    n_checks++; if (cause !== 4'd3) begin n_fail++; $display("[TB] FAIL take_cause: got %0d expected %0d", cause, 3); end
    n_checks++; if (irq_ack !== 4'b0010) begin n_fail++; $display("[TB] FAIL take_ack: got %b expected %b", irq_ack, 4'b0010); end
    n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("[TB] FAIL take_pending: got %b expected %b", pending, 4'b0100); end
    irq = 4'b0000; pcin = 32'h8000_0010;
    cycle();
    n_checks++; if (irq_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL take_ack_clear: got %b expected %b", irq_ack, 4'b0000); end
    n_checks++; if (ia !== 32'h8000_0010) begin n_fail++; $display("[TB] FAIL take_sup_hold: got %h expected %h", ia, 32'h8000_0010); end
  endtask

  task automatic test_exc_vs_irq();
    to_user(32'h0000_1000);
    pcin = 32'h0000_1004; exception = 1'b1; irq = 4'b0001;
    cycle();
    n_checks++; if (ia !== 32'h8000_0004) begin n_fail++; $display("[TB] FAIL exc_ia: got %h expected %h", ia, 32'h8000_0004); end
    n_checks++; if (cause !== 4'd1) begin n_fail++; $display("[TB] FAIL exc_cause: got %0d expected %0d", cause, 1); end
    n_checks++; if (epc !== 32'h0000_1004) begin n_fail++; $display("[TB] FAIL exc_epc: got %h expected %h", epc, 32'h0000_1004); end
    n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("[TB] FAIL exc_pending: got %b expected %b", pending, 4'b0001); end
    n_checks++; if (irq_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL exc_ack: got %b expected %b", irq_ack, 4'b0000); end
    exception = 1'b0; irq = 4'b0000; eret = 1'b1; pcin = 32'h8000_0008;
    cycle();
    n_checks++; if (ia !== 32'h0000_1004) begin n_fail++; $display("[TB] FAIL eret_ia: got %h expected %h", ia, 32'h0000_1004); end
    n_checks++; if (cause !== 4'd1) begin n_fail++; $display("[TB] FAIL eret_cause: got %0d expected %0d", cause, 1); end
    eret = 1'b0; pcin = 32'h0000_1008;
    cycle();
    n_checks++; if (ia !== 32'h8000_0008) begin n_fail++; $display("[TB] FAIL post_eret_ia: got %h expected %h", ia, 32'h8000_0008); end
    n_checks++; if (epc !== 32'h0000_1008) begin n_fail++; $display("[TB] FAIL post_eret_epc: got %h expected %h", epc, 32'h0000_1008); end
    n_checks++; if (cause !== 4'd2) begin n_fail++; $display("[TB] FAIL post_eret_cause: got %0d expected %0d", cause, 2); end
    n_checks++; if (irq_ack !== 4'b0001) begin n_fail++; $display("[TB] FAIL post_eret_ack: got %b expected %b", irq_ack, 4'b0001); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("[TB] FAIL post_eret_pending: got %b expected %b", pending, 4'b0000); end
  endtask

  task automatic test_stall();
    to_user(32'h0000_1000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      irq  = (i == 0) ? 4'b0100 : 4'b0000;
      pcin = 32'h0000_2000 + 32'(i * 4);
      cycle();
      n_checks++; if (ia !== 32'h0000_1000) begin n_fail++; $display("[TB] FAIL stall_ia[%0d]: got %h expected %h", i, ia, 32'h0000_1000); end
      n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("[TB] FAIL stall_pending[%0d]: got %b expected %b", i, pending, 4'b0100); end
      n_checks++; if (irq_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL stall_ack[%0d]: got %b expected %b", i, irq_ack, 4'b0000); end
    end
    stall = 1'b0; irq = 4'b0000; pcin = 32'h0000_1004;
    cycle();
    n_checks++; if (ia !== 32'h8000_0010) begin n_fail++; $display("[TB] FAIL unstall_ia: got %h expected %h", ia, 32'h8000_0010); end
    n_checks++; if (irq_ack !== 4'b0100) begin n_fail++; $display("[TB] FAIL unstall_ack: got %b expected %b", irq_ack, 4'b0100); end
    n_checks++; if (cause !== 4'd4) begin n_fail++; $display("[TB] FAIL unstall_cause: got %0d expected %0d", cause, 4); end
    n_checks++; if (epc !== 32'h0000_1004) begin n_fail++; $display("[TB] FAIL unstall_epc: got %h expected %h", epc, 32'h0000_1004); end
  endtask

  task automatic test_mask();
    to_user(32'h0000_1000);
    irq = 4'b0010; irq_mask = 4'b1101; pcin = 32'h0000_1004;
    cycle();
    n_checks++; if (ia !== 32'h0000_1004) begin n_fail++; $display("[TB] FAIL mask_ia: got %h expected %h", ia, 32'h0000_1004); end
    n_checks++; if (pending !== 4'b0010) begin n_fail++; $display("[TB] FAIL mask_pending: got %b expected %b", pending, 4'b0010); end
    n_checks++; if (irq_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL mask_ack: got %b expected %b", irq_ack, 4'b0000); end
    irq = 4'b0000; irq_mask = 4'b1111; pcin = 32'h0000_1008;
    cycle();
    n_checks++; if (ia !== 32'h8000_000C) begin n_fail++; $display("[TB] FAIL unmask_ia: got %h expected %h", ia, 32'h8000_000C); end
    n_checks++; if (cause !== 4'd3) begin n_fail++; $display("[TB] FAIL unmask_cause: got %0d expected %0d", cause, 3); end
    n_checks++; if (irq_ack !== 4'b0010) begin n_fail++; $display("[TB] FAIL unmask_ack: got %b expected %b", irq_ack, 4'b0010); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("[TB] FAIL unmask_pending: got %b expected %b", pending, 4'b0000); end
  endtask

  task automatic test_eret_supervisor();
    to_user(32'h0000_1000);
    exception = 1'b1; pcin = 32'h0000_2000;
    cycle();
    exception = 1'b0; pcin = 32'h8000_0100;
    cycle();
    n_checks++; if (ia !== 32'h8000_0100) begin n_fail++; $display("[TB] FAIL sup_setup_ia: got %h expected %h", ia, 32'h8000_0100); end
    irq = 4'b0001; eret = 1'b1; pcin = 32'h8000_0104;
    cycle();
    n_checks++; if (ia !== 32'h0000_2000) begin n_fail++; $display("[TB] FAIL sup_eret_ia: got %h expected %h", ia, 32'h0000_2000); end
    n_checks++; if (irq_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL sup_eret_ack: got %b expected %b", irq_ack, 4'b0000); end
    n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("[TB] FAIL sup_eret_pending: got %b expected %b", pending, 4'b0001); end
    irq = 4'b0000; eret = 1'b0; pcin = 32'h0000_2004;
    cycle();
    n_checks++; if (ia !== 32'h8000_0008) begin n_fail++; $display("[TB] FAIL sup_next_ia: got %h expected %h", ia, 32'h8000_0008); end
    n_checks++; if (epc !== 32'h0000_2004) begin n_fail++; $display("[TB] FAIL sup_next_epc: got %h expected %h", epc, 32'h0000_2004); end
    n_checks++; if (irq_ack !== 4'b0001) begin n_fail++; $display("[TB] FAIL sup_next_ack: got %b expected %b", irq_ack, 4'b0001); end
  endtask

  task automatic test_reset_mid_stall();
    to_user(32'h0000_1000);
    stall = 1'b1; exception = 1'b1; irq = 4'b1010;
    cycle();
    reset = 1'b1; irq = 4'b0000;
    cycle();
    n_checks++; if (ia !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL rst_stall_ia: got %h expected %h", ia, 32'h8000_0000); end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_stall_pending: got %b expected %b", pending, 4'b0000); end
    reset = 1'b0; stall = 1'b0; exception = 1'b0; pcin = 32'h0000_3000;
    cycle();
    n_checks++; if (ia !== 32'h0000_3000) begin n_fail++; $display("[TB] FAIL rst_after_ia: got %h expected %h", ia, 32'h0000_3000); end
    n_checks++; if (cause !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_after_cause: got %0d expected %0d", cause, 0); end
    n_checks++; if (irq_ack !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_after_ack: got %b expected %b", irq_ack, 4'b0000); end
  endtask

  initial begin
    idle_inputs();
    pcin = 32'h0;
    test_reset();
    test_supervisor_latch();
    test_irq_take();
    test_exc_vs_irq();
    test_stall();
    test_mask();
    test_eret_supervisor();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
